// File: rtl/ctr_update_keystream_if.sv
// AES core request/ack bus between the CTR_DRBG keystream sequencer and a shared AES-256 core.
// Handshake: the master holds aes_req, aes_key and aes_block stable until the slave
// answers with a one-cycle aes_ack carrying aes_result; aes_ack is ignored while aes_req=0.
interface ctr_update_keystream_if #(
    parameter int KEYLEN   = 256,
    parameter int BLOCKLEN = 128
);
    logic                aes_req;
    logic [KEYLEN-1:0]   aes_key;
    logic [BLOCKLEN-1:0] aes_block;
    logic                aes_ack;
    logic [BLOCKLEN-1:0] aes_result;
    logic [1:0]          fsm_state;

    modport master (
        output aes_req, aes_key, aes_block, fsm_state,
        input  aes_ack, aes_result
    );

    modport slave (
        input  aes_req, aes_key, aes_block, fsm_state,
        output aes_ack, aes_result
    );
endinterface

// File: rtl/ctr_update_keystream.sv
// CTR_DRBG update keystream: AES(K,V+1..V+3) concatenated, XORed with provided_data.
// First encryption lands in the MSBs of seed_out.
module ctr_update_keystream #(
    parameter int KEYLEN   = 256,
    parameter int BLOCKLEN = 128,
    parameter int SEEDLEN  = 384
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEYLEN-1:0]   key_in,
    input  logic [BLOCKLEN-1:0] v_in,
    input  logic [SEEDLEN-1:0]  provided_data,
    ctr_update_keystream_if.master aes,
    output logic [SEEDLEN-1:0]  seed_out,
    output logic                done,
    output logic                busy
);
    localparam int NUM_BLOCKS = SEEDLEN / BLOCKLEN;
    localparam int CNT_W      = $clog2(NUM_BLOCKS);
    localparam int TEMP_W     = SEEDLEN - BLOCKLEN;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BLOCKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_INC  = 2'd1,
        S_REQ  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CNT_W-1:0]    cnt;
    logic [KEYLEN-1:0]   k_reg;
    logic [BLOCKLEN-1:0] v_reg;
    logic [SEEDLEN-1:0]  pd_reg;
    logic [TEMP_W-1:0]   temp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_INC;
            S_INC:  state_nx = S_REQ;
            S_REQ: begin
                if (aes.aes_ack) begin
                    state_nx = (cnt == LAST) ? S_IDLE : S_INC;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Request outputs decode straight from state so reset withdraws aes_req asynchronously.
    always_comb begin
        aes.aes_req   = (state == S_REQ);
        aes.aes_key   = (state == S_REQ) ? k_reg : '0;
        aes.aes_block = (state == S_REQ) ? v_reg : '0;
        aes.fsm_state = state;
        busy          = (state != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            k_reg    <= '0;
            v_reg    <= '0;
            pd_reg   <= '0;
            temp     <= '0;
            seed_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        k_reg  <= key_in;
                        v_reg  <= v_in;
                        pd_reg <= provided_data;
                        cnt    <= '0;
                        temp   <= '0;
                    end
                end
                S_INC: v_reg <= v_reg + BLOCKLEN'(1);
                S_REQ: begin
                    if (aes.aes_ack) begin
                        if (cnt == LAST) begin
                            seed_out <= {temp, aes.aes_result} ^ pd_reg;
                            done     <= 1'b1;
                        end else begin
                            // Shift earlier blocks toward the MSBs as each result arrives.
                            temp <= {temp[TEMP_W-BLOCKLEN-1:0], aes.aes_result};
                            cnt  <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ctr_update_keystream.sv
// Directed bench for ctr_update_keystream with an XOR-based AES stub of programmable ack latency.
// Expected seeds and AES blocks are queued by the driver and popped by the monitor and stub.
module tb_ctr_update_keystream;
    logic         clk;
    logic         rst;
    logic         start;
    logic [255:0] key_in;
    logic [127:0] v_in;
    logic [383:0] provided_data;
    logic [383:0] seed_out;
    logic         done;
    logic         busy;

    ctr_update_keystream_if aes_bus ();

    ctr_update_keystream dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .key_in        (key_in),
        .v_in          (v_in),
        .provided_data (provided_data),
        .aes           (aes_bus),
        .seed_out      (seed_out),
        .done          (done),
        .busy          (busy)
    );

    logic [383:0] exp_q[$];
    logic [127:0] blk_q[$];
    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;
    int lat      = 0;
    bit spurious = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AES stub: result = block ^ key[127:0], ack after lat wait cycles in each request
    int           wcnt = 0;
    bit           req_prev = 0;
    logic [255:0] key_prev;
    logic [127:0] blk_prev;
    always @(negedge clk) begin
        if (aes_bus.aes_req) begin
            if (req_prev) begin
                check("req_key_stable", aes_bus.aes_key, key_prev);
                check("req_block_stable", aes_bus.aes_block, blk_prev);
            end
            if (wcnt >= lat) begin
                aes_bus.aes_ack    = 1'b1;
                aes_bus.aes_result = aes_bus.aes_block ^ aes_bus.aes_key[127:0];
                wcnt = 0;
                if (blk_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL aes_block_unexpected: got %0h expected none", aes_bus.aes_block);
                end else begin
                    check("aes_block", aes_bus.aes_block, blk_q.pop_front());
                end
            end else begin
                aes_bus.aes_ack = 1'b0;
                wcnt++;
            end
        end else begin
            wcnt = 0;
            if (spurious) begin
                aes_bus.aes_ack    = 1'($urandom_range(0, 1));
                aes_bus.aes_result = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                aes_bus.aes_ack = 1'b0;
            end
        end
        req_prev = aes_bus.aes_req;
        key_prev = aes_bus.aes_key;
        blk_prev = aes_bus.aes_block;
    end

    // monitor: pop expected seed on every done pulse
    bit done_prev = 0;
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            check("done_width", {383'd0, done_prev}, 384'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL done_unexpected: got seed %0h expected no done", seed_out);
            end else begin
                check("seed_out", seed_out, exp_q.pop_front());
            end
        end
        done_prev = done;
    end

    task automatic push_run(input logic [127:0] b0, b1, b2, input logic [383:0] seed);
        blk_q.push_back(b0);
        blk_q.push_back(b1);
        blk_q.push_back(b2);
        exp_q.push_back(seed);
    endtask

    // issue one start pulse, then count cycles to done and busy-high cycles
    task automatic run(input logic [255:0] k, input logic [127:0] v, input logic [383:0] pd,
                       input int exp_lat);
        int cycles;
        int busy_cycles;
        @(negedge clk);
        key_in        = k;
        v_in          = v;
        provided_data = pd;
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        key_in        = ~k;
        v_in          = ~v;
        provided_data = ~pd;
        cycles      = 0;
        busy_cycles = 0;
        while (!done && cycles < 200) begin
            busy_cycles += int'(busy);
            @(posedge clk);
            #1 cycles++;
        end
        check("latency", 384'(cycles), 384'(exp_lat));
        check("busy_cycles", 384'(busy_cycles), 384'(exp_lat));
    endtask

    initial begin
        int d0;
        int c;
        rst           = 1'b1;
        start         = 1'b0;
        key_in        = '0;
        v_in          = '0;
        provided_data = '0;
        aes_bus.aes_ack    = 1'b0;
        aes_bus.aes_result = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_seed_out", seed_out, 384'd0);
        check("rst_done", {383'd0, done}, 384'd0);
        check("rst_busy", {383'd0, busy}, 384'd0);
        check("rst_aes_req", {383'd0, aes_bus.aes_req}, 384'd0);
        check("rst_aes_key", {128'd0, aes_bus.aes_key}, 384'd0);
        check("rst_aes_block", {256'd0, aes_bus.aes_block}, 384'd0);
        #1 rst = 1'b0;

        // zero vectors
        push_run(128'h1, 128'h2, 128'h3, {128'h1, 128'h2, 128'h3});
        run('0, '0, '0, 6);

        // V wrap
        push_run(128'h0, 128'h1, 128'h2, {128'h0, 128'h1, 128'h2});
        run('0, {128{1'b1}}, '0, 6);

        // XOR and key path; upper key half is outside the stub's result
        push_run(128'h1, 128'h2, 128'h3,
                 {{15{8'h5A}}, 8'h5B, {15{8'h5A}}, 8'h58, {15{8'h5A}}, 8'h59});
        run({128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, {16{8'hA5}}}, '0, {384{1'b1}}, 6);

        // ack latency 5 with spurious acks outside REQ
        lat      = 5;
        spurious = 1;
        push_run(128'h11, 128'h12, 128'h13, {128'h10, 128'h10, 128'h10});
        run('0, 128'h10, {128'h1, 128'h2, 128'h3}, 21);
        repeat (5) @(posedge clk);
        #1 check("seed_hold", seed_out, {128'h10, 128'h10, 128'h10});

        // continuous start with key/V change mid-operation
        lat = 0;
        d0  = n_done;
        push_run(128'h1, 128'h2, 128'h3, {128'h0E, 128'h0D, 128'h0C});
        push_run(128'h101, 128'h102, 128'h103, {128'h1F1, 128'h1F2, 128'h1F3});
        @(negedge clk);
        key_in        = 256'h0F;
        v_in          = '0;
        provided_data = '0;
        start         = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        key_in = 256'hF0;
        v_in   = 128'h100;
        c = 0;
        while (!done && c < 100) begin
            @(posedge clk);
            #1 c++;
        end
        check("run1_done", {383'd0, done}, {383'd0, 1'b1});
        @(posedge clk);
        #1 start = 1'b0;
        c = 0;
        while (!done && c < 100) begin
            @(posedge clk);
            #1 c++;
        end
        check("run2_latency", 384'(c), 384'd6);
        repeat (10) @(posedge clk);
        #1;
        check("done_per_run", 384'(n_done - d0), 384'd2);
        check("idle_busy", {383'd0, busy}, 384'd0);

        // reset during the second request
        lat = 2;
        blk_q.push_back(128'h1);
        @(negedge clk);
        key_in        = '0;
        v_in          = '0;
        provided_data = '0;
        start         = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("second_req_up", {383'd0, aes_bus.aes_req}, {383'd0, 1'b1});
        d0 = n_done;
        #1 rst = 1'b1;
        #1;
        check("abort_aes_req", {383'd0, aes_bus.aes_req}, 384'd0);
        check("abort_busy", {383'd0, busy}, 384'd0);
        check("abort_seed_out", seed_out, 384'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        lat = 0;
        push_run(128'h8, 128'h9, 128'hA, {128'h8, 128'h9, 128'hA});
        run('0, 128'h7, '0, 6);
        repeat (3) @(posedge clk);
        #1;
        check("done_after_abort", 384'(n_done - d0), 384'd1);
        check("seed_q_drained", 384'(exp_q.size()), 384'd0);
        check("blk_q_drained", 384'(blk_q.size()), 384'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
